// File: rtl/alu_mc32.sv
// Multi-cycle ALU with valid/ready handshakes; MUL uses an iterative shift-add datapath.
// Optional macro ALU_MULT_HI_EN adds R_HI, the upper half of the signed MUL product.
module alu_mc32 #(
   parameter int WIDTH     = 32,
   parameter int MUL_RADIX = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       S,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] R,
   output logic             zero,
   output logic             carry,
   output logic             ovf
`ifdef ALU_MULT_HI_EN
   ,
   output logic [WIDTH-1:0] R_HI
`endif
);
   localparam int STEPS = WIDTH / MUL_RADIX;
   localparam int CW    = $clog2(STEPS + 1);

   localparam logic [2:0] opAdd = 3'b000, opXor = 3'b001, opSub = 3'b010, opMul = 3'b011,
                          opSlt = 3'b100, opNor = 3'b101, opAnd = 3'b110, opOr  = 3'b111;

   generate
      if (WIDTH % MUL_RADIX != 0) begin : gBadRadix
         $error("alu_mc32: WIDTH must be divisible by MUL_RADIX");
      end
      if (MUL_RADIX != 1 && MUL_RADIX != 2 && MUL_RADIX != 4) begin : gBadRadixVal
         $error("alu_mc32: MUL_RADIX must be 1, 2 or 4");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
   state_t state, nextState;

   logic readyEn, acceptOp, mulFinish;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] mplier;
   logic signed [2*WIDTH-1:0] mcand, acc, digX, pp;
   logic [MUL_RADIX:0] dig;
   logic [WIDTH:0] addSum, subSum;
   logic [WIDTH-1:0] aluR;
   logic aluC, aluV, mulOvf;

   // readyEn keeps in_ready low until the first clock after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) readyEn <= 1'b0;
      else        readyEn <= 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nextState;
   end

   always_comb begin
      nextState = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      acceptOp  = 1'b0;
      mulFinish = 1'b0;
      case (state)
         IDLE: begin
            in_ready = readyEn;
            if (in_valid && readyEn) begin
               acceptOp  = 1'b1;
               nextState = (S == opMul) ? MUL : DONE;
            end
         end
         MUL: begin
            if (cnt == '0) begin
               mulFinish = 1'b1;
               nextState = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) begin
               if (in_valid) begin
                  acceptOp  = 1'b1;
                  nextState = (S == opMul) ? MUL : DONE;
               end else begin
                  nextState = IDLE;
               end
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // single-cycle ops, evaluated on the live inputs at the accepting edge
   always_comb begin
      addSum = {1'b0, A} + {1'b0, B};
      subSum = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
      aluR   = '0;
      aluC   = 1'b0;
      aluV   = 1'b0;
      case (S)
         opAdd: begin
            aluR = addSum[WIDTH-1:0];
            aluC = addSum[WIDTH];
            aluV = (A[WIDTH-1] == B[WIDTH-1]) && (addSum[WIDTH-1] != A[WIDTH-1]);
         end
         opSub: begin
            aluR = subSum[WIDTH-1:0];
            aluC = ~subSum[WIDTH];
            aluV = (A[WIDTH-1] != B[WIDTH-1]) && (subSum[WIDTH-1] != A[WIDTH-1]);
         end
         opXor:   aluR = A ^ B;
         opSlt:   aluR = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         opNor:   aluR = ~(A | B);
         opAnd:   aluR = A & B;
         opOr:    aluR = A | B;
         default: aluR = '0;
      endcase
   end

   // The top multiplier digit carries negative weight, so it is sign-extended on the last step.
   always_comb begin
      dig    = {(cnt == CW'(1)) & mplier[MUL_RADIX-1], mplier[MUL_RADIX-1:0]};
      digX   = {{(2*WIDTH-MUL_RADIX-1){dig[MUL_RADIX]}}, dig};
      pp     = mcand * digX;
      mulOvf = acc[2*WIDTH-1:WIDTH] != {WIDTH{acc[WIDTH-1]}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         R      <= '0;
         zero   <= 1'b0;
         carry  <= 1'b0;
         ovf    <= 1'b0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
`ifdef ALU_MULT_HI_EN
         R_HI   <= '0;
`endif
      end else if (acceptOp) begin
         if (S == opMul) begin
            mcand  <= {{WIDTH{A[WIDTH-1]}}, A};
            mplier <= B;
            acc    <= '0;
            cnt    <= CW'(STEPS);
         end else begin
            R     <= aluR;
            zero  <= (aluR == '0);
            carry <= aluC;
            ovf   <= aluV;
`ifdef ALU_MULT_HI_EN
            R_HI  <= '0;
`endif
         end
      end else if (state == MUL) begin
         if (cnt != '0) begin
            acc    <= acc + pp;
            mcand  <= mcand << MUL_RADIX;
            mplier <= mplier >> MUL_RADIX;
            cnt    <= cnt - CW'(1);
         end else if (mulFinish) begin
            R     <= acc[WIDTH-1:0];
            zero  <= (acc[WIDTH-1:0] == '0);
            carry <= 1'b0;
            ovf   <= mulOvf;
`ifdef ALU_MULT_HI_EN
            R_HI  <= acc[2*WIDTH-1:WIDTH];
`endif
         end
      end
   end
endmodule

// File: tb/tb_alu_mc32.sv
// Directed bench for alu_mc32: handshake timing, arithmetic flags, MUL latency, back-pressure, reset abort.
module tb_alu_mc32;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] A, B, R;
   logic [2:0]  S;
   logic        zero, carry, ovf;
`ifdef ALU_MULT_HI_EN
   logic [31:0] R_HI;
`endif
   int nTotal = 0;
   int nBad   = 0;

   alu_mc32 #(.WIDTH(32), .MUL_RADIX(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .S(S), .out_valid(out_valid), .out_ready(out_ready),
      .R(R), .zero(zero), .carry(carry), .ovf(ovf)
`ifdef ALU_MULT_HI_EN
      , .R_HI(R_HI)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nTotal++;
      if (got !== exp) begin
         nBad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      in_valid = 1'b1;
      S = op;
      A = a;
      B = b;
   endtask

   logic [31:0] strA [8] = '{32'h00FF0000, 32'h0F0F0F0F, 32'h00000001, 32'h00000000,
                             32'h80000000, 32'hFFFF0000, 32'h12340000, 32'hAAAAAAAA};
   logic [31:0] strB [8] = '{32'h0000FF00, 32'hF0F0F0F0, 32'h00000002, 32'h00000000,
                             32'h00000001, 32'h0000FF00, 32'h00005678, 32'h11111111};
   logic [31:0] strR [8] = '{32'h00FFFF00, 32'h00000000, 32'h00000003, 32'hFFFFFFFF,
                             32'h80000001, 32'h000000FF, 32'h12345678, 32'h44444444};

   initial begin
      int n;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; S = '0;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_R", R, 32'd0);
      chk("rst_zero", 32'(zero), 32'd0);
      chk("rst_carry", 32'(carry), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready_low", 32'(in_ready), 32'd0);
      tick();
      chk("rel_in_ready_high", 32'(in_ready), 32'd1);

      // ADD wrap, then back-to-back SUB / SUB borrow / SLT
      issue(3'b000, 32'hFFFF_FFFF, 32'h1);
      tick();
      chk("add_valid", 32'(out_valid), 32'd1);
      chk("add_R", R, 32'h0);
      chk("add_zero", 32'(zero), 32'd1);
      chk("add_carry", 32'(carry), 32'd1);
      chk("add_ovf", 32'(ovf), 32'd0);
      issue(3'b010, 32'h8000_0000, 32'h1);
      tick();
      chk("sub_R", R, 32'h7FFF_FFFF);
      chk("sub_ovf", 32'(ovf), 32'd1);
      chk("sub_carry", 32'(carry), 32'd0);
      issue(3'b010, 32'h1, 32'h2);
      tick();
      chk("subb_R", R, 32'hFFFF_FFFF);
      chk("subb_carry", 32'(carry), 32'd1);
      chk("subb_ovf", 32'(ovf), 32'd0);
      issue(3'b100, 32'hFFFF_FFFF, 32'h0);
      tick();
      chk("slt_R", R, 32'h1);
      chk("slt_zero", 32'(zero), 32'd0);
      in_valid = 1'b0;
      tick();
      chk("idle_out_valid", 32'(out_valid), 32'd0);

      // MUL -3 * 7
      issue(3'b011, 32'hFFFF_FFFD, 32'h7);
      tick();
      in_valid = 1'b0; A = 32'hDEAD_BEEF; B = 32'h1234_5678;
      chk("mul_in_ready", 32'(in_ready), 32'd0);
      n = 0;
      while (!out_valid && n < 60) begin tick(); n++; end
      chk("mul_lat", 32'(n), 32'd33);
      chk("mul_R", R, 32'hFFFF_FFEB);
      chk("mul_ovf", 32'(ovf), 32'd0);
      chk("mul_carry", 32'(carry), 32'd0);
`ifdef ALU_MULT_HI_EN
      chk("mul_R_HI", R_HI, 32'hFFFF_FFFF);
`endif
      tick();
      // MUL 2^16 * 2^16 overflows the low half
      issue(3'b011, 32'h0001_0000, 32'h0001_0000);
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 60) begin tick(); n++; end
      chk("mulo_lat", 32'(n), 32'd33);
      chk("mulo_R", R, 32'h0);
      chk("mulo_zero", 32'(zero), 32'd1);
      chk("mulo_ovf", 32'(ovf), 32'd1);
`ifdef ALU_MULT_HI_EN
      chk("mulo_R_HI", R_HI, 32'h1);
`endif
      tick();

      // back-pressure on an XOR result, AND queued behind it
      out_ready = 1'b0;
      issue(3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00);
      tick();
      issue(3'b110, 32'hFFFF_0000, 32'h1234_5678);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_R", R, 32'h0FF0_0FF0);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(in_ready), 32'd1);
      tick();
      chk("bp_and_valid", 32'(out_valid), 32'd1);
      chk("bp_and_R", R, 32'h1234_0000);
      in_valid = 1'b0;
      tick();

      // stream alternating OR / NOR
      for (int i = 0; i < 8; i++) begin
         issue((i % 2 == 0) ? 3'b111 : 3'b101, strA[i], strB[i]);
         tick();
         chk("stream_valid", 32'(out_valid), 32'd1);
         chk("stream_R", R, strR[i]);
      end
      in_valid = 1'b0;
      tick();

      // reset abort during MUL
      issue(3'b011, 32'd123, 32'd456);
      tick();
      in_valid = 1'b0;
      repeat (10) tick();
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_R", R, 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      issue(3'b000, 32'd2, 32'd3);
      tick();
      chk("post_add_valid", 32'(out_valid), 32'd1);
      chk("post_add_R", R, 32'd5);
      in_valid = 1'b0;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (out_valid) n++;
      end
      chk("no_stale_result", 32'(n), 32'd0);

      $display("test done: total=%0d bad=%0d", nTotal, nBad);
      $finish;
   end
endmodule
